// File: rtl/laser_fire_pkg.sv
// Shared types and widths for the laser fire controller and its window comparator.
package laser_fire_pkg;

    localparam int ANGLE_W = 16;
    localparam int CW_W    = 8;
    localparam int DLY_W   = 8;
    localparam int FW_W    = 4;
    localparam int CNT_W   = 16;
    localparam int TMR_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHARGE = 2'd1,
        ST_DELAY  = 2'd2,
        ST_FIRE   = 2'd3
    } state_t;

    // Phase length is max(len,1); the timer counts down to zero, so load len-1.
    function automatic logic [TMR_W-1:0] len_to_tmr(input logic [TMR_W-1:0] len);
        return (len == '0) ? '0 : len - TMR_W'(1);
    endfunction

endpackage

// File: rtl/angle_window_cmp.sv
// Combinational angle window test; start > stop wraps through zero, start == stop admits all angles.
module angle_window_cmp
    import laser_fire_pkg::*;
(
    input  logic [ANGLE_W-1:0] i_angle,
    input  logic [ANGLE_W-1:0] i_start,
    input  logic [ANGLE_W-1:0] i_stop,
    output logic               o_in_win
);

    always_comb begin
        if (i_start < i_stop) begin
            o_in_win = (i_angle >= i_start) && (i_angle <= i_stop);
        end else if (i_start > i_stop) begin
            o_in_win = (i_angle >= i_start) || (i_angle <= i_stop);
        end else begin
            o_in_win = 1'b1;
        end
    end

endmodule

// File: rtl/laser_fire_ctrl.sv
// Angle-triggered charge/delay/fire sequencer with per-frame dropped-sync accounting.
module laser_fire_ctrl
    import laser_fire_pkg::*;
(
    input  logic               i_clk_50m,
    input  logic               i_rst_n,
    input  logic               i_angle_sync,
    input  logic [ANGLE_W-1:0] i_code_angle,
    input  logic               i_zero_sign,
    input  logic               i_motor_state,
    input  logic               i_encoder_right,
    input  logic               i_laser_mode,
    input  logic               i_measure_mode,
    input  logic [ANGLE_W-1:0] i_angle_start,
    input  logic [ANGLE_W-1:0] i_angle_stop,
    input  logic [CW_W-1:0]    i_charge_width,
    input  logic [DLY_W-1:0]   i_fire_delay,
    input  logic [FW_W-1:0]    i_fire_width,
    output logic               o_laser_charge,
    output logic               o_laser_fire,
    output logic               o_fire_valid,
    output logic [ANGLE_W-1:0] o_fire_angle,
    output logic               o_busy,
    output logic [CNT_W-1:0]   o_frame_cnt,
    output logic [CNT_W-1:0]   o_miss_cnt
);

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic [CW_W-1:0]    cw_q, cw_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [FW_W-1:0]    fw_q, fw_d;
    logic               charge_q, charge_d;
    logic               fire_q, fire_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   frame_q, frame_d;
    logic [CNT_W-1:0]   miss_int_q, miss_int_d;
    logic [CNT_W-1:0]   miss_out_q, miss_out_d;

    logic en, in_win, hit, accept, miss;

    angle_window_cmp u_win (
        .i_angle  (i_code_angle),
        .i_start  (i_angle_start),
        .i_stop   (i_angle_stop),
        .o_in_win (in_win)
    );

    assign en     = i_laser_mode & i_measure_mode & i_motor_state & i_encoder_right;
    assign hit    = i_angle_sync & en & in_win;
    assign accept = hit & (state_q == ST_IDLE);
    assign miss   = hit & (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        angle_d = angle_q;
        cw_d    = cw_q;
        dly_d   = dly_q;
        fw_d    = fw_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_CHARGE;
                    tmr_d   = len_to_tmr(i_charge_width);
                    angle_d = i_code_angle;
                    cw_d    = i_charge_width;
                    dly_d   = i_fire_delay;
                    fw_d    = i_fire_width;
                end
            end
            ST_CHARGE: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else if (dly_q == '0) begin
                    state_d = ST_FIRE;
                    tmr_d   = len_to_tmr({{(TMR_W-FW_W){1'b0}}, fw_q});
                end else begin
                    state_d = ST_DELAY;
                    tmr_d   = dly_q - TMR_W'(1);
                end
            end
            ST_DELAY: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else begin
                    state_d = ST_FIRE;
                    tmr_d   = len_to_tmr({{(TMR_W-FW_W){1'b0}}, fw_q});
                end
            end
            ST_FIRE: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Losing enable overrides any sequencing in progress.
        if ((state_q != ST_IDLE) && !en) begin
            state_d = ST_IDLE;
        end

        // Drives are registered from the next state so they are glitch-free and never overlap.
        charge_d = (state_d == ST_CHARGE);
        fire_d   = (state_d == ST_FIRE);
        valid_d  = (state_d == ST_FIRE) && (state_q != ST_FIRE);
    end

    always_comb begin
        frame_d    = frame_q;
        miss_int_d = miss_int_q;
        miss_out_d = miss_out_q;
        if (i_zero_sign) begin
            frame_d    = frame_q + CNT_W'(1);
            miss_out_d = miss_int_q;
            miss_int_d = miss ? CNT_W'(1) : '0;
        end else if (miss && (miss_int_q != '1)) begin
            miss_int_d = miss_int_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            angle_q    <= '0;
            cw_q       <= '0;
            dly_q      <= '0;
            fw_q       <= '0;
            charge_q   <= 1'b0;
            fire_q     <= 1'b0;
            valid_q    <= 1'b0;
            frame_q    <= '0;
            miss_int_q <= '0;
            miss_out_q <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            angle_q    <= angle_d;
            cw_q       <= cw_d;
            dly_q      <= dly_d;
            fw_q       <= fw_d;
            charge_q   <= charge_d;
            fire_q     <= fire_d;
            valid_q    <= valid_d;
            frame_q    <= frame_d;
            miss_int_q <= miss_int_d;
            miss_out_q <= miss_out_d;
        end
    end

    assign o_laser_charge = charge_q;
    assign o_laser_fire   = fire_q;
    assign o_fire_valid   = valid_q;
    assign o_fire_angle   = angle_q;
    assign o_busy         = (state_q != ST_IDLE);
    assign o_frame_cnt    = frame_q;
    assign o_miss_cnt     = miss_out_q;

endmodule

// File: tb/tb_laser_fire_ctrl.sv
// Directed bench for laser_fire_ctrl: window/enable vector table plus multi-cycle sequences.
module tb_laser_fire_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync = 1'b0;
    logic [15:0] angle = '0;
    logic        zero = 1'b0;
    logic        motor = 1'b1;
    logic        enc = 1'b1;
    logic        lmode = 1'b1;
    logic        mmode = 1'b1;
    logic [15:0] a_start = '0;
    logic [15:0] a_stop = 16'hFFFF;
    logic [7:0]  cw = '0;
    logic [7:0]  dly = '0;
    logic [3:0]  fw = '0;
    logic        charge, fire, fvalid, busy;
    logic [15:0] fangle, frame, misses;

    int n_chk = 0;
    int n_fail = 0;
    int n_valid;
    logic [15:0] exp_frame = '0;
    logic [15:0] exp_angle = '0;

    always #10 clk = ~clk;

    laser_fire_ctrl dut (
        .i_clk_50m       (clk),
        .i_rst_n         (rst_n),
        .i_angle_sync    (sync),
        .i_code_angle    (angle),
        .i_zero_sign     (zero),
        .i_motor_state   (motor),
        .i_encoder_right (enc),
        .i_laser_mode    (lmode),
        .i_measure_mode  (mmode),
        .i_angle_start   (a_start),
        .i_angle_stop    (a_stop),
        .i_charge_width  (cw),
        .i_fire_delay    (dly),
        .i_fire_width    (fw),
        .o_laser_charge  (charge),
        .o_laser_fire    (fire),
        .o_fire_valid    (fvalid),
        .o_fire_angle    (fangle),
        .o_busy          (busy),
        .o_frame_cnt     (frame),
        .o_miss_cnt      (misses)
    );

    typedef struct {
        logic [15:0] start;
        logic [15:0] stop;
        logic [15:0] ang;
        logic [3:0]  en;   // {laser_mode, measure_mode, motor_state, encoder_right}
        logic        acc;
    } vec_t;

    vec_t vecs [16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic zero_pulse();
        zero = 1'b1;
        step();
        zero = 1'b0;
        exp_frame = exp_frame + 16'd1;
    endtask

    task automatic wait_idle(input int limit);
        int i;
        i = 0;
        while (busy && i < limit) begin
            step();
            i++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{16'h0000, 16'hFFFF, 16'h0123, 4'hF, 1'b1};
        vecs[1]  = '{16'h1000, 16'h2000, 16'h1000, 4'hF, 1'b1};
        vecs[2]  = '{16'h1000, 16'h2000, 16'h2000, 4'hF, 1'b1};
        vecs[3]  = '{16'h1000, 16'h2000, 16'h0FFF, 4'hF, 1'b0};
        vecs[4]  = '{16'h1000, 16'h2000, 16'h2001, 4'hF, 1'b0};
        vecs[5]  = '{16'hF000, 16'h0100, 16'hF800, 4'hF, 1'b1};
        vecs[6]  = '{16'hF000, 16'h0100, 16'h0050, 4'hF, 1'b1};
        vecs[7]  = '{16'hF000, 16'h0100, 16'h8000, 4'hF, 1'b0};
        vecs[8]  = '{16'hF000, 16'h0100, 16'hF000, 4'hF, 1'b1};
        vecs[9]  = '{16'hF000, 16'h0100, 16'h0101, 4'hF, 1'b0};
        vecs[10] = '{16'h5555, 16'h5555, 16'h1234, 4'hF, 1'b1};
        vecs[11] = '{16'h0000, 16'hFFFF, 16'h0200, 4'h7, 1'b0};
        vecs[12] = '{16'h0000, 16'hFFFF, 16'h0300, 4'hB, 1'b0};
        vecs[13] = '{16'h0000, 16'hFFFF, 16'h0400, 4'hD, 1'b0};
        vecs[14] = '{16'h0000, 16'hFFFF, 16'h0500, 4'hE, 1'b0};
        vecs[15] = '{16'h0100, 16'h0200, 16'h0180, 4'hF, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_charge", {31'd0, charge}, 32'd0);
        chk("rst_fire", {31'd0, fire}, 32'd0);
        chk("rst_valid", {31'd0, fvalid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_angle", {16'd0, fangle}, 32'd0);
        chk("rst_frame", {16'd0, frame}, 32'd0);
        chk("rst_miss", {16'd0, misses}, 32'd0);
        rst_n = 1'b1;
        step();

        // Basic shot, with width inputs changed right after acceptance
        a_start = 16'h0000; a_stop = 16'hFFFF;
        cw = 8'd10; dly = 8'd5; fw = 4'd3; angle = 16'h0123;
        sync = 1'b1;
        step();
        sync = 1'b0;
        cw = 8'd2; dly = 8'd0; fw = 4'd15; angle = 16'hAAAA;
        for (int k = 1; k <= 21; k++) begin
            chk($sformatf("basic_charge_T+%0d", k), {31'd0, charge}, {31'd0, (k <= 10)});
            chk($sformatf("basic_fire_T+%0d", k), {31'd0, fire}, {31'd0, (k >= 16 && k <= 18)});
            chk($sformatf("basic_valid_T+%0d", k), {31'd0, fvalid}, {31'd0, (k == 16)});
            chk("basic_overlap", {31'd0, charge & fire}, 32'd0);
            step();
        end
        chk("basic_angle", {16'd0, fangle}, 32'h0123);
        chk("basic_idle", {31'd0, busy}, 32'd0);

        // Zero widths, then immediate re-accept on the cycle after FIRE
        cw = 8'd0; dly = 8'd0; fw = 4'd0; angle = 16'h0456;
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("zw_charge_T+1", {31'd0, charge}, 32'd1);
        chk("zw_fire_T+1", {31'd0, fire}, 32'd0);
        step();
        chk("zw_charge_T+2", {31'd0, charge}, 32'd0);
        chk("zw_fire_T+2", {31'd0, fire}, 32'd1);
        chk("zw_valid_T+2", {31'd0, fvalid}, 32'd1);
        step();
        chk("zw_busy_T+3", {31'd0, busy}, 32'd0);
        chk("zw_fire_T+3", {31'd0, fire}, 32'd0);
        angle = 16'h0457;
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("reaccept_charge", {31'd0, charge}, 32'd1);
        chk("reaccept_angle", {16'd0, fangle}, 32'h0457);
        exp_angle = 16'h0457;
        step();
        step();

        // Window / enable table
        for (int i = 0; i < 16; i++) begin
            a_start = vecs[i].start;
            a_stop  = vecs[i].stop;
            angle   = vecs[i].ang;
            {lmode, mmode, motor, enc} = vecs[i].en;
            sync = 1'b1;
            step();
            sync = 1'b0;
            {lmode, mmode, motor, enc} = 4'hF;
            chk($sformatf("vec%0d_accept", i), {31'd0, busy}, {31'd0, vecs[i].acc});
            if (vecs[i].acc) exp_angle = vecs[i].ang;
            chk($sformatf("vec%0d_angle", i), {16'd0, fangle}, {16'd0, exp_angle});
            step(); step(); step();
            chk($sformatf("vec%0d_idle", i), {31'd0, busy}, 32'd0);
        end

        // Nothing so far was a busy drop
        zero_pulse();
        chk("frame_after_table", {16'd0, frame}, {16'd0, exp_frame});
        chk("miss_after_table", {16'd0, misses}, 32'd0);

        // Busy overlap: second sync at T+5 is dropped and counted
        a_start = 16'h0000; a_stop = 16'hFFFF;
        cw = 8'd20; dly = 8'd0; fw = 4'd0; angle = 16'h0777;
        sync = 1'b1;
        step();
        n_valid = 0;
        for (int i = 1; i <= 30; i++) begin
            sync = (i == 5);
            if (fvalid) n_valid++;
            step();
        end
        sync = 1'b0;
        chk("overlap_shots", n_valid, 32'd1);
        chk("overlap_idle", {31'd0, busy}, 32'd0);
        zero_pulse();
        chk("overlap_miss", {16'd0, misses}, 32'd1);
        chk("overlap_frame", {16'd0, frame}, {16'd0, exp_frame});

        // Miss and zero pulse in the same cycle
        sync = 1'b1;
        step();
        sync = 1'b0;
        step(); step();
        sync = 1'b1;
        zero = 1'b1;
        step();
        sync = 1'b0;
        zero = 1'b0;
        exp_frame = exp_frame + 16'd1;
        chk("same_cycle_miss_out", {16'd0, misses}, 32'd0);
        chk("same_cycle_frame", {16'd0, frame}, {16'd0, exp_frame});
        wait_idle(40);
        zero_pulse();
        chk("same_cycle_internal", {16'd0, misses}, 32'd1);

        // Sync and zero together while idle are independent
        cw = 8'd0; dly = 8'd0; fw = 4'd0;
        sync = 1'b1;
        zero = 1'b1;
        step();
        sync = 1'b0;
        zero = 1'b0;
        exp_frame = exp_frame + 16'd1;
        chk("sync_zero_busy", {31'd0, busy}, 32'd1);
        chk("sync_zero_frame", {16'd0, frame}, {16'd0, exp_frame});
        chk("sync_zero_miss", {16'd0, misses}, 32'd0);
        wait_idle(10);

        // Abort: motor drops during DELAY
        cw = 8'd2; dly = 8'd5; fw = 4'd3;
        sync = 1'b1;
        step();
        sync = 1'b0;
        step(); step(); step();
        chk("abort_pre_busy", {31'd0, busy}, 32'd1);
        chk("abort_pre_charge", {31'd0, charge}, 32'd0);
        motor = 1'b0;
        step();
        chk("abort_busy", {31'd0, busy}, 32'd0);
        motor = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("abort_no_fire", {31'd0, fire}, 32'd0);
            chk("abort_no_valid", {31'd0, fvalid}, 32'd0);
            chk("abort_no_charge", {31'd0, charge}, 32'd0);
            step();
        end

        // Asynchronous reset during CHARGE
        cw = 8'd20; dly = 8'd0; fw = 4'd0;
        sync = 1'b1;
        step();
        sync = 1'b0;
        step(); step();
        chk("arst_pre_charge", {31'd0, charge}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_charge", {31'd0, charge}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_frame", {16'd0, frame}, 32'd0);
        chk("arst_miss", {16'd0, misses}, 32'd0);
        chk("arst_angle", {16'd0, fangle}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
